// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock: BCD digit type
// and the digit limits of a valid 24-hour HH:MM time.
package alarm_clock_pkg;

   localparam int unsigned BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   localparam bcd_digit_t MAX_MS_HR       = 4'd2;
   localparam bcd_digit_t MAX_LS_HR_AT_20 = 4'd3;
   localparam bcd_digit_t MAX_MS_MIN      = 4'd5;
   localparam bcd_digit_t MAX_LS_DIGIT    = 4'd9;

endpackage

// File: rtl/time_load_check.sv
// Combinational validity check of a BCD HH:MM time.
// Ports: ms_hr_i, ls_hr_i, ms_min_i, ls_min_i in; valid_o out.
module time_load_check
   import alarm_clock_pkg::*;
(
   input  bcd_digit_t ms_hr_i,
   input  bcd_digit_t ls_hr_i,
   input  bcd_digit_t ms_min_i,
   input  bcd_digit_t ls_min_i,
   output logic       valid_o
);

   // Hours 20..23 restrict the units digit to 0..3.
   assign valid_o = (ms_hr_i  <= MAX_MS_HR)
                 && (ls_hr_i  <= MAX_LS_DIGIT)
                 && (ms_min_i <= MAX_MS_MIN)
                 && (ls_min_i <= MAX_LS_DIGIT)
                 && ((ms_hr_i < MAX_MS_HR)
                     || (ls_hr_i <= MAX_LS_HR_AT_20));

endmodule

// File: rtl/time_counter.sv
// Time-of-day keeper: counts one_second strobes into BCD HH:MM,
// with validated parallel load. Outputs: digits, minute_tick, load_err.
module time_counter
   import alarm_clock_pkg::*;
#(
   parameter int unsigned SEC_PER_MIN = 60
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_second,
   input  logic       load_new_c,
   input  bcd_digit_t new_current_time_ms_hr,
   input  bcd_digit_t new_current_time_ls_hr,
   input  bcd_digit_t new_current_time_ms_min,
   input  bcd_digit_t new_current_time_ls_min,
   output bcd_digit_t current_time_ms_hr,
   output bcd_digit_t current_time_ls_hr,
   output bcd_digit_t current_time_ms_min,
   output bcd_digit_t current_time_ls_min,
   output logic       minute_tick,
   output logic       load_err
);

   localparam int unsigned SEC_W = $clog2(SEC_PER_MIN);
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

   bcd_digit_t       ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
   bcd_digit_t       ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
   logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;
   logic             new_ok;

   time_load_check u_check (
      .ms_hr_i  (new_current_time_ms_hr),
      .ls_hr_i  (new_current_time_ls_hr),
      .ms_min_i (new_current_time_ms_min),
      .ls_min_i (new_current_time_ls_min),
      .valid_o  (new_ok)
   );

   always_comb begin
      ms_hr_d   = ms_hr_q;
      ls_hr_d   = ls_hr_q;
      ms_min_d  = ms_min_q;
      ls_min_d  = ls_min_q;
      sec_cnt_d = sec_cnt_q;
      tick_d    = 1'b0;
      err_d     = 1'b0;
      if (load_new_c && new_ok) begin
         // A valid load overrides any same-cycle strobe.
         ms_hr_d   = new_current_time_ms_hr;
         ls_hr_d   = new_current_time_ls_hr;
         ms_min_d  = new_current_time_ms_min;
         ls_min_d  = new_current_time_ls_min;
         sec_cnt_d = '0;
      end else begin
         err_d = load_new_c;
         if (one_second) begin
            if (sec_cnt_q == SEC_LAST) begin
               sec_cnt_d = '0;
               tick_d    = 1'b1;
               if (ls_min_q != MAX_LS_DIGIT) begin
                  ls_min_d = ls_min_q + 4'd1;
               end else begin
                  ls_min_d = '0;
                  if (ms_min_q != MAX_MS_MIN) begin
                     ms_min_d = ms_min_q + 4'd1;
                  end else begin
                     ms_min_d = '0;
                     if (ms_hr_q == MAX_MS_HR
                         && ls_hr_q == MAX_LS_HR_AT_20) begin
                        ms_hr_d = '0;
                        ls_hr_d = '0;
                     end else if (ls_hr_q == MAX_LS_DIGIT) begin
                        ls_hr_d = '0;
                        ms_hr_d = ms_hr_q + 4'd1;
                     end else begin
                        ls_hr_d = ls_hr_q + 4'd1;
                     end
                  end
               end
            end else begin
               sec_cnt_d = sec_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ms_hr_q   <= '0;
         ls_hr_q   <= '0;
         ms_min_q  <= '0;
         ls_min_q  <= '0;
         sec_cnt_q <= '0;
         tick_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         ms_hr_q   <= ms_hr_d;
         ls_hr_q   <= ls_hr_d;
         ms_min_q  <= ms_min_d;
         ls_min_q  <= ls_min_d;
         sec_cnt_q <= sec_cnt_d;
         tick_q    <= tick_d;
         err_q     <= err_d;
      end
   end

   assign current_time_ms_hr  = ms_hr_q;
   assign current_time_ls_hr  = ls_hr_q;
   assign current_time_ms_min = ms_min_q;
   assign current_time_ls_min = ls_min_q;
   assign minute_tick         = tick_q;
   assign load_err            = err_q;

endmodule
